// File: rtl/pwm_duty_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_duty_gen_pkg : FSM encodings, duty constants and ramp helper           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pwm_duty_gen_pkg;

    localparam int DUTY_STEPS = 7;
    localparam int DUTY_W     = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One soft-ramp step of the applied duty towards the requested duty.
    function automatic logic [DUTY_W-1:0] duty_ramp(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt
    );
        logic [DUTY_W-1:0] nxt;
        nxt = cur;
        if (tgt > cur) begin
            nxt = cur + DUTY_W'(1);
        end else if (tgt < cur) begin
            nxt = cur - DUTY_W'(1);
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_gen_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_duty_gen_deadtime : complementary output pair with dead-time insertion |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm_duty_gen_deadtime #(
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy_i,
    input  logic pwm_i,
    output logic pwm_o,
    output logic pwm_n_o
);

    localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    logic            prev_q;
    logic [DT_W-1:0] dt_q;
    logic [DT_W-1:0] dt_d;
    logic            out_q;
    logic            out_d;
    logic            n_q;
    logic            n_d;
    logic            w_edge;
    logic            w_hold;

    // Any edge (re)arms the counter, so a pulse shorter than the dead time never
    // reaches the output that would have turned on.
    always_comb begin
        w_edge = pwm_i ^ prev_q;
        w_hold = w_edge | (dt_q != '0);
        dt_d   = dt_q;
        if (!busy_i || w_edge) begin
            dt_d = DT_W'(DEADTIME - 1);
        end else if (dt_q != '0) begin
            dt_d = dt_q - DT_W'(1);
        end
        out_d = busy_i & pwm_i & ~w_hold;
        n_d   = busy_i & ~pwm_i & ~w_hold;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
            dt_q   <= '0;
            out_q  <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            prev_q <= pwm_i;
            dt_q   <= dt_d;
            out_q  <= out_d;
            n_q    <= n_d;
        end
    end

    assign pwm_o   = out_q;
    assign pwm_n_o = n_q;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_duty_gen : soft-ramped 3-bit duty PWM; PWM_DEADTIME_EN adds pwm_n pair |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pwm_duty_gen
    import pwm_duty_gen_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter int STEP     = 100,
    parameter int DEADTIME = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_num,
    output logic              pwm_out,
    output logic              pwm_n,
    output logic              period_tick,
    output logic [DUTY_W-1:0] duty_eff,
    output logic              busy
);

    localparam int PERIOD = DUTY_STEPS * STEP;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int PROD_W = CNT_W + 1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DUTY_W-1:0] target_q;
    logic [PRE_W-1:0]  presc_q;
    logic [PRE_W-1:0]  presc_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic              pwm_q;
    logic              pwm_d;
    logic              ptick_q;
    logic              ptick_d;

    logic              w_busy;
    logic              w_tick;
    logic              w_wrap;
    logic [PROD_W-1:0] w_thresh;

    assign w_busy   = (state_q != ST_IDLE);
    assign w_tick   = w_busy && (presc_q == PRE_W'(PRESCALE - 1));
    assign w_wrap   = w_tick && (cnt_q == CNT_W'(PERIOD - 1));
    assign w_thresh = PROD_W'(duty_q) * PROD_W'(STEP);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        ptick_d = w_wrap;
        pwm_d   = w_busy && ({1'b0, cnt_q} < w_thresh);

        if (w_busy) begin
            presc_d = w_tick ? '0 : presc_q + PRE_W'(1);
            if (w_tick) begin
                cnt_d = w_wrap ? '0 : cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                cnt_d   = '0;
                duty_d  = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wrap) begin
                    duty_d = duty_ramp(duty_q, target_q);
                end
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A re-enable simply resumes RUN; the current period carries on untouched.
                if (enable) begin
                    state_d = ST_RUN;
                    if (w_wrap) begin
                        duty_d = duty_ramp(duty_q, target_q);
                    end
                end else if (w_wrap) begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                cnt_d   = '0;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            ptick_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= duty_num;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            ptick_q  <= ptick_d;
        end
    end

    assign period_tick = ptick_q;
    assign duty_eff    = duty_q;
    assign busy        = w_busy;

`ifdef PWM_DEADTIME_EN
    pwm_duty_gen_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk     (clk),
        .reset_n (reset_n),
        .busy_i  (w_busy),
        .pwm_i   (pwm_q),
        .pwm_o   (pwm_out),
        .pwm_n_o (pwm_n)
    );
`else
    logic w_unused_deadtime;
    assign w_unused_deadtime = (DEADTIME > 0);
    assign pwm_out           = pwm_q;
    assign pwm_n             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_duty_gen : randomized self-checking bench against a period model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pwm_duty_gen;

    localparam int PRESCALE = 2;
    localparam int STEP     = 4;
    localparam int DEADTIME = 3;
    localparam int PCLK     = 7 * STEP * PRESCALE;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] duty_num = 3'd0;
    logic       pwm_out;
    logic       pwm_n;
    logic       period_tick;
    logic [2:0] duty_eff;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference model: applied duty, requested duty, and whether a stop is pending.
    int mdl_eff = 0;
    int mdl_tgt = 0;
    bit mdl_drain = 1'b0;
    // Recent undelayed compare results, used for the dead-time output model.
    bit raw_hist[$];
    bit busy_prev = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_gen #(
        .PRESCALE (PRESCALE),
        .STEP     (STEP),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .duty_num    (duty_num),
        .pwm_out     (pwm_out),
        .pwm_n       (pwm_n),
        .period_tick (period_tick),
        .duty_eff    (duty_eff),
        .busy        (busy)
    );

    task automatic tick_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_hist(input bit raw, input bit b);
        raw_hist.push_back(raw);
        if (raw_hist.size() > DEADTIME + 1) begin
            void'(raw_hist.pop_front());
        end
        busy_prev = b;
    endtask

    function automatic bit exp_pwm_out(input bit raw_now);
        bit all1;
`ifdef PWM_DEADTIME_EN
        all1 = busy_prev && (raw_hist.size() == DEADTIME + 1);
        foreach (raw_hist[k]) all1 &= raw_hist[k];
`else
        all1 = raw_now;
`endif
        return all1;
    endfunction

    task automatic clear_model();
        mdl_eff   = 0;
        mdl_drain = 1'b0;
        raw_hist.delete();
        busy_prev = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick_clk();
        push_hist(1'b0, 1'b1);
        mdl_eff   = 0;
        mdl_drain = 1'b0;
        checks++;
        if (busy !== 1'b1 || duty_eff !== 3'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL start_run: busy=%b duty_eff=%0d period_tick=%b, want 1/0/0",
                     busy, duty_eff, period_tick);
        end
    endtask

    // One full PWM period from just after a wrap (or start); enable/duty_num are
    // driven at the given sample indices (0 = never).
    task automatic run_period(input int drop_at, input int reen_at, input int tgt_at, input int tgt_val);
        logic [PCLK-1:0] exp_p;
        logic [PCLK-1:0] got_p;
        int  duty_bad = 0;
        int  tick_bad = 0;
        int  busy_bad = 0;
        int  n_bad    = 0;
        bit  end_idle = 1'b0;
        bit  raw;
        int  eff_now;
        eff_now = mdl_eff;
        for (int i = 1; i <= PCLK; i++) begin
            if (i == drop_at) enable = 1'b0;
            if (i == reen_at) enable = 1'b1;
            if (i == tgt_at) begin
                duty_num = 3'(tgt_val);
                mdl_tgt  = tgt_val;
            end
            if (i < PCLK) begin
                mdl_drain = !enable;
            end else begin
                if (mdl_drain && !enable) begin
                    end_idle = 1'b1;
                    mdl_eff  = 0;
                end else if (mdl_tgt > mdl_eff) begin
                    mdl_eff = mdl_eff + 1;
                end else if (mdl_tgt < mdl_eff) begin
                    mdl_eff = mdl_eff - 1;
                end
                mdl_drain = !enable;
            end
            tick_clk();
            raw = ((i - 1) / PRESCALE) < (eff_now * STEP);
            exp_p[i-1] = exp_pwm_out(raw);
            got_p[i-1] = pwm_out;
            push_hist(raw, !(end_idle && i == PCLK));
            if (duty_eff !== 3'((i == PCLK) ? mdl_eff : eff_now)) duty_bad++;
            if (period_tick !== (i == PCLK)) tick_bad++;
            if (busy !== !(end_idle && i == PCLK)) busy_bad++;
`ifndef PWM_DEADTIME_EN
            if (pwm_n !== 1'b0) n_bad++;
`endif
        end
        checks++;
        if (got_p !== exp_p) begin
            errors++;
            $display("FAIL period_pwm eff=%0d: got %h want %h", eff_now, got_p, exp_p);
        end
        checks++;
        if (duty_bad != 0) begin
            errors++;
            $display("FAIL period_duty_eff: %0d bad samples (want 0), end value %0d want %0d",
                     duty_bad, duty_eff, mdl_eff);
        end
        checks++;
        if (tick_bad != 0) begin
            errors++;
            $display("FAIL period_tick: %0d bad samples, want 0", tick_bad);
        end
        checks++;
        if (busy_bad + n_bad != 0) begin
            errors++;
            $display("FAIL period_busy_pwm_n: %0d busy and %0d pwm_n bad samples, want 0", busy_bad, n_bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable   = 1'($urandom);
            duty_num = 3'($urandom);
            tick_clk();
            checks++;
            if ({pwm_out, pwm_n, period_tick, busy, duty_eff} !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold: outputs %b, want 0000000",
                         {pwm_out, pwm_n, period_tick, busy, duty_eff});
            end
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            duty_num = 3'($urandom);
            tick_clk();
            checks++;
            if ({pwm_out, pwm_n, period_tick, busy, duty_eff} !== 7'd0) begin
                errors++;
                $display("FAIL reset_release_idle: outputs %b, want 0000000",
                         {pwm_out, pwm_n, period_tick, busy, duty_eff});
            end
        end
        duty_num = 3'd0;
        mdl_tgt  = 0;
        clear_model();
        for (int i = 0; i < DEADTIME + 1; i++) push_hist(1'b0, 1'b0);
    endtask

    task automatic test_ramp();
        duty_num = 3'd3;
        mdl_tgt  = 3;
        start_run();
        for (int p = 0; p < 5; p++) run_period(0, 0, 0, 0);
        checks++;
        if (duty_eff !== 3'd3) begin
            errors++;
            $display("FAIL ramp_final: duty_eff=%0d want 3", duty_eff);
        end
    endtask

    task automatic test_mid_change();
        run_period(0, 0, 20, 5);
        run_period(0, 0, 0, 0);
    endtask

    task automatic test_extremes();
        for (int p = 0; p < 9; p++) run_period(0, 0, (p == 0) ? 1 : 0, 7);
        checks++;
        if (duty_eff !== 3'd7) begin
            errors++;
            $display("FAIL extreme_high: duty_eff=%0d want 7", duty_eff);
        end
        for (int p = 0; p < 9; p++) run_period(0, 0, (p == 0) ? 1 : 0, 0);
        checks++;
        if (duty_eff !== 3'd0) begin
            errors++;
            $display("FAIL extreme_low: duty_eff=%0d want 0", duty_eff);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 8; p++) begin
            run_period(0, 0, int'($urandom_range(1, PCLK - 1)), int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_drain();
        int idle_bad = 0;
        run_period(10, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            push_hist(1'b0, 1'b0);
            if ({pwm_out, pwm_n, period_tick, busy, duty_eff} !== 7'd0) idle_bad++;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL drain_idle: %0d non-zero idle samples, want 0", idle_bad);
        end
    endtask

    task automatic test_reenable();
        start_run();
        run_period(10, 40, 0, 0);
        run_period(0, 0, 0, 0);
    endtask

    task automatic test_drop_at_wrap();
        run_period(PCLK, 0, 0, 0);
        run_period(0, 0, 0, 0);
    endtask

    task automatic test_reset_midperiod();
        duty_num = 3'd6;
        mdl_tgt  = 6;
        start_run();
        for (int p = 0; p < 2; p++) run_period(0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            tick_clk();
            push_hist(1'b0, 1'b1);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, pwm_n, period_tick, busy, duty_eff} !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: outputs %b, want 0000000",
                     {pwm_out, pwm_n, period_tick, busy, duty_eff});
        end
        enable = 1'b0;
        tick_clk();
        tick_clk();
        reset_n = 1'b1;
        clear_model();
        for (int i = 0; i < DEADTIME + 1; i++) push_hist(1'b0, 1'b0);
    endtask

    task automatic test_deadtime();
        bit o_rec[2*PCLK];
        bit n_rec[2*PCLK];
        int overlap = 0;
        int gaps = 0;
        int bad_gap = 0;
        int run_len = 0;
        bit seen_high = 1'b0;
        duty_num = 3'd2;
        mdl_tgt  = 2;
        start_run();
        for (int p = 0; p < 3; p++) run_period(0, 0, 0, 0);
        for (int i = 0; i < 2 * PCLK; i++) begin
            tick_clk();
            o_rec[i] = pwm_out;
            n_rec[i] = pwm_n;
        end
`ifdef PWM_DEADTIME_EN
        for (int i = 0; i < 2 * PCLK; i++) begin
            if (o_rec[i] && n_rec[i]) overlap++;
            if (!o_rec[i] && !n_rec[i]) begin
                run_len++;
            end else begin
                if (seen_high && run_len > 0) begin
                    gaps++;
                    if (run_len != DEADTIME) bad_gap++;
                end
                run_len   = 0;
                seen_high = 1'b1;
            end
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL deadtime_overlap: %0d samples with both high, want 0", overlap);
        end
        checks++;
        if (gaps != 4) begin
            errors++;
            $display("FAIL deadtime_gap_count: %0d gaps, want 4", gaps);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL deadtime_gap_len: %0d gaps not %0d clk long, want 0", bad_gap, DEADTIME);
        end
`else
        for (int i = 0; i < 2 * PCLK; i++) begin
            if (n_rec[i]) overlap++;
            if (o_rec[i]) run_len++;
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL pwm_n_tied: %0d samples high, want 0", overlap);
        end
        checks++;
        if (run_len != 2 * 2 * STEP * PRESCALE) begin
            errors++;
            $display("FAIL duty2_high_count: %0d, want %0d", run_len, 2 * 2 * STEP * PRESCALE);
        end
        gaps    = 0;
        bad_gap = 0;
        seen_high = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_mid_change();
        test_extremes();
        test_random();
        test_drain();
        test_reenable();
        test_drop_at_wrap();
        test_reset_midperiod();
        test_deadtime();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
